// File: rtl/mem_arbiter.sv
// Byte-serial RAM port shared by instruction fetch and load/store, with round-robin
// grant, little-endian read assembly, IO write back-pressure and flush handling.
module mem_arbiter #(
   parameter int                ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] IO_MASK = 32'h00030000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clear_in,
   input  logic              if_req_in,
   input  logic [ADDR_W-1:0] if_addr_in,
   output logic              if_done_out,
   output logic [31:0]       if_data_out,
   input  logic              ls_req_in,
   input  logic              ls_we_in,
   input  logic [1:0]        ls_size_in,
   input  logic [ADDR_W-1:0] ls_addr_in,
   input  logic [31:0]       ls_wdata_in,
   output logic              ls_done_out,
   output logic [31:0]       ls_rdata_out,
   input  logic [7:0]        ram_din_in,
   output logic [7:0]        ram_dout_out,
   output logic [ADDR_W-1:0] ram_a_out,
   output logic              ram_wr_out,
   input  logic              io_buffer_full_in
);

   typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

   state_t            state;
   logic [2:0]        cnt;
   logic [2:0]        n_bytes;
   logic [ADDR_W-1:0] base;
   logic [31:0]       wdata;
   logic [31:0]       rbuf;
   logic              last_ls;
   logic              is_io;
   logic              wr;
   logic [7:0]        held_byte;
   logic              held_valid;

   logic [2:0]        cnt_nx;
   logic [1:0]        sidx;
   logic [7:0]        byte_in;
   logic [31:0]       merged;
   logic [2:0]        ls_n;
   logic              ls_io;
   logic              if_win;

   // Read bytes lag their address by one cycle. While rdy is low the address is
   // frozen, so the byte that was due at the first frozen edge is kept in held_byte
   // and used in place of ram_din_in on the edge that resumes.
   always_comb begin
      cnt_nx  = cnt + 3'd1;
      sidx    = cnt[1:0] - 2'd1;
      byte_in = held_valid ? held_byte : ram_din_in;
      merged  = rbuf;
      merged[{sidx, 3'b000} +: 8] = byte_in;
      ls_n    = (ls_size_in == 2'd0) ? 3'd1 : ((ls_size_in == 2'd1) ? 3'd2 : 3'd4);
      ls_io   = (ls_addr_in & IO_MASK) == IO_MASK;
      if_win  = if_req_in && !clear_in && (!ls_req_in || last_ls);
   end

   assign ram_wr_out = wr & rdy;

   // cnt counts cycles since grant for reads and bytes issued for writes.
   // An IO store granted while the buffer is full starts stalled with no byte issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 3'd0;
         n_bytes      <= 3'd0;
         base         <= '0;
         wdata        <= 32'd0;
         rbuf         <= 32'd0;
         last_ls      <= 1'b1;
         is_io        <= 1'b0;
         wr           <= 1'b0;
         held_byte    <= 8'd0;
         held_valid   <= 1'b0;
         ram_a_out    <= '0;
         ram_dout_out <= 8'd0;
         if_done_out  <= 1'b0;
         if_data_out  <= 32'd0;
         ls_done_out  <= 1'b0;
         ls_rdata_out <= 32'd0;
      end else if (!rdy) begin
         if (!held_valid) begin
            held_byte  <= ram_din_in;
            held_valid <= 1'b1;
         end
      end else begin
         held_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (if_win) begin
                  state     <= IF_RD;
                  last_ls   <= 1'b0;
                  base      <= if_addr_in;
                  ram_a_out <= if_addr_in;
                  n_bytes   <= 3'd4;
                  cnt       <= 3'd0;
                  rbuf      <= 32'd0;
               end else if (ls_req_in) begin
                  last_ls   <= 1'b1;
                  base      <= ls_addr_in;
                  ram_a_out <= ls_addr_in;
                  n_bytes   <= ls_n;
                  rbuf      <= 32'd0;
                  wdata     <= ls_wdata_in;
                  is_io     <= ls_io;
                  if (!ls_we_in) begin
                     state <= LS_RD;
                     cnt   <= 3'd0;
                  end else if (ls_io && io_buffer_full_in) begin
                     state <= LS_WR;
                     wr    <= 1'b0;
                     cnt   <= 3'd0;
                  end else begin
                     state        <= LS_WR;
                     wr           <= 1'b1;
                     ram_dout_out <= ls_wdata_in[7:0];
                     cnt          <= 3'd1;
                  end
               end
            end
            IF_RD, LS_RD: begin
               if (clear_in) begin
                  state <= IDLE;
                  cnt   <= 3'd0;
               end else begin
                  if (cnt_nx < n_bytes)
                     ram_a_out <= base + ADDR_W'(cnt_nx);
                  if (cnt == n_bytes) begin
                     state <= DONE;
                     if (state == IF_RD) begin
                        if_done_out <= 1'b1;
                        if_data_out <= merged;
                     end else begin
                        ls_done_out  <= 1'b1;
                        ls_rdata_out <= merged;
                     end
                  end else if (cnt != 3'd0) begin
                     rbuf <= merged;
                  end
                  cnt <= cnt_nx;
               end
            end
            LS_WR: begin
               if (cnt == n_bytes) begin
                  state       <= DONE;
                  wr          <= 1'b0;
                  ls_done_out <= 1'b1;
               end else if (is_io && io_buffer_full_in) begin
                  wr <= 1'b0;
               end else begin
                  ram_a_out    <= base + ADDR_W'(cnt);
                  ram_dout_out <= wdata[{cnt[1:0], 3'b000} +: 8];
                  wr           <= 1'b1;
                  cnt          <= cnt_nx;
               end
            end
            DONE: begin
               state       <= IDLE;
               cnt         <= 3'd0;
               if_done_out <= 1'b0;
               ls_done_out <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte RAM model with one-cycle read latency,
// one task per scenario with hand-computed expectations.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        clear_in;
   logic        if_req_in;
   logic [31:0] if_addr_in;
   logic        if_done_out;
   logic [31:0] if_data_out;
   logic        ls_req_in;
   logic        ls_we_in;
   logic [1:0]  ls_size_in;
   logic [31:0] ls_addr_in;
   logic [31:0] ls_wdata_in;
   logic        ls_done_out;
   logic [31:0] ls_rdata_out;
   logic [7:0]  ram_din_in;
   logic [7:0]  ram_dout_out;
   logic [31:0] ram_a_out;
   logic        ram_wr_out;
   logic        io_buffer_full_in;

   logic [7:0]  mem [0:65535];
   int          passed = 0;
   int          total = 0;

   mem_arbiter #(.ADDR_W(32), .IO_MASK(32'h00030000)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear_in(clear_in),
      .if_req_in(if_req_in), .if_addr_in(if_addr_in),
      .if_done_out(if_done_out), .if_data_out(if_data_out),
      .ls_req_in(ls_req_in), .ls_we_in(ls_we_in), .ls_size_in(ls_size_in),
      .ls_addr_in(ls_addr_in), .ls_wdata_in(ls_wdata_in),
      .ls_done_out(ls_done_out), .ls_rdata_out(ls_rdata_out),
      .ram_din_in(ram_din_in), .ram_dout_out(ram_dout_out),
      .ram_a_out(ram_a_out), .ram_wr_out(ram_wr_out),
      .io_buffer_full_in(io_buffer_full_in)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM model: data for the address seen in one cycle appears in the next.
   // Fixed contents are (re)loaded while reset is held.
   always @(posedge clk) begin
      if (rst) begin
         mem[16'h0100] <= 8'h13;
         mem[16'h0101] <= 8'h05;
         mem[16'h0102] <= 8'h00;
         mem[16'h0103] <= 8'h00;
         mem[16'h0300] <= 8'h11;
         mem[16'h0301] <= 8'h22;
         mem[16'h0302] <= 8'h33;
         mem[16'h0303] <= 8'h44;
         mem[16'h0202] <= 8'h77;
      end else if (ram_wr_out) begin
         mem[ram_a_out[15:0]] <= ram_dout_out;
      end
      ram_din_in <= mem[ram_a_out[15:0]];
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset;
      if_req_in = 1'b0;
      ls_req_in = 1'b0;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; rdy = 1'b1; clear_in = 1'b0;
      if_req_in = 1'b0; if_addr_in = 32'd0;
      ls_req_in = 1'b0; ls_we_in = 1'b0; ls_size_in = 2'd0;
      ls_addr_in = 32'd0; ls_wdata_in = 32'd0; io_buffer_full_in = 1'b0;
      step(2);
      total++; if (ram_a_out !== 32'd0) $display("[TB] FAIL reset_addr got %h expected %h", ram_a_out, 32'd0); else passed++;
      total++; if (ram_wr_out !== 1'b0) $display("[TB] FAIL reset_wr got %b expected 0", ram_wr_out); else passed++;
      total++; if (ram_dout_out !== 8'd0) $display("[TB] FAIL reset_dout got %h expected 00", ram_dout_out); else passed++;
      total++; if (if_done_out !== 1'b0) $display("[TB] FAIL reset_if_done got %b expected 0", if_done_out); else passed++;
      total++; if (ls_done_out !== 1'b0) $display("[TB] FAIL reset_ls_done got %b expected 0", ls_done_out); else passed++;
      total++; if (if_data_out !== 32'd0) $display("[TB] FAIL reset_if_data got %h expected 0", if_data_out); else passed++;
      total++; if (ls_rdata_out !== 32'd0) $display("[TB] FAIL reset_ls_rdata got %h expected 0", ls_rdata_out); else passed++;
      rst = 1'b0;
      step(1);
   endtask

   task automatic test_lone_fetch;
      if_addr_in = 32'h100; if_req_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(1);
         total++; if (ram_a_out !== 32'h100 + k) $display("[TB] FAIL fetch_addr[%0d] got %h expected %h", k, ram_a_out, 32'h100 + k); else passed++;
      end
      step(1);
      total++; if (if_done_out !== 1'b0) $display("[TB] FAIL fetch_early_done got %b expected 0", if_done_out); else passed++;
      step(1);
      total++; if (if_done_out !== 1'b1) $display("[TB] FAIL fetch_done got %b expected 1", if_done_out); else passed++;
      total++; if (if_data_out !== 32'h00000513) $display("[TB] FAIL fetch_data got %h expected 00000513", if_data_out); else passed++;
      if_req_in = 1'b0;
      step(1);
      total++; if (if_done_out !== 1'b0) $display("[TB] FAIL fetch_done_pulse got %b expected 0", if_done_out); else passed++;
      total++; if (if_data_out !== 32'h00000513) $display("[TB] FAIL fetch_data_hold got %h expected 00000513", if_data_out); else passed++;
   endtask

   task automatic test_round_robin;
      do_reset();
      if_addr_in = 32'h100; if_req_in = 1'b1;
      ls_addr_in = 32'h300; ls_we_in = 1'b0; ls_size_in = 2'd2; ls_req_in = 1'b1;
      step(1);
      total++; if (ram_a_out !== 32'h100) $display("[TB] FAIL rr_grant1_if got %h expected 00000100", ram_a_out); else passed++;
      step(5);
      total++; if (if_done_out !== 1'b1) $display("[TB] FAIL rr_if_done got %b expected 1", if_done_out); else passed++;
      step(1);
      total++; if (ram_a_out !== 32'h103) $display("[TB] FAIL rr_no_grant_in_done1 got %h expected 00000103", ram_a_out); else passed++;
      step(1);
      total++; if (ram_a_out !== 32'h300) $display("[TB] FAIL rr_grant2_ls got %h expected 00000300", ram_a_out); else passed++;
      step(5);
      total++; if (ls_done_out !== 1'b1) $display("[TB] FAIL rr_ls_done got %b expected 1", ls_done_out); else passed++;
      total++; if (ls_rdata_out !== 32'h44332211) $display("[TB] FAIL rr_ls_data got %h expected 44332211", ls_rdata_out); else passed++;
      step(1);
      total++; if (ram_a_out !== 32'h303) $display("[TB] FAIL rr_no_grant_in_done2 got %h expected 00000303", ram_a_out); else passed++;
      step(1);
      total++; if (ram_a_out !== 32'h100) $display("[TB] FAIL rr_grant3_if got %h expected 00000100", ram_a_out); else passed++;
      ls_req_in = 1'b0;
      step(5);
      total++; if (if_done_out !== 1'b1) $display("[TB] FAIL rr_if_done2 got %b expected 1", if_done_out); else passed++;
      if_req_in = 1'b0;
      step(1);
   endtask

   task automatic test_store_2b;
      io_buffer_full_in = 1'b1;
      ls_addr_in = 32'h200; ls_we_in = 1'b1; ls_size_in = 2'd1; ls_wdata_in = 32'hABCD1234; ls_req_in = 1'b1;
      step(1);
      total++; if ({ram_wr_out, ram_a_out, ram_dout_out} !== {1'b1, 32'h200, 8'h34}) $display("[TB] FAIL st2_byte0 got wr=%b a=%h d=%h expected wr=1 a=00000200 d=34", ram_wr_out, ram_a_out, ram_dout_out); else passed++;
      step(1);
      total++; if ({ram_wr_out, ram_a_out, ram_dout_out} !== {1'b1, 32'h201, 8'h12}) $display("[TB] FAIL st2_byte1 got wr=%b a=%h d=%h expected wr=1 a=00000201 d=12", ram_wr_out, ram_a_out, ram_dout_out); else passed++;
      step(1);
      total++; if (ls_done_out !== 1'b1) $display("[TB] FAIL st2_done got %b expected 1", ls_done_out); else passed++;
      total++; if (ram_wr_out !== 1'b0) $display("[TB] FAIL st2_wr_off got %b expected 0", ram_wr_out); else passed++;
      ls_req_in = 1'b0; io_buffer_full_in = 1'b0;
      step(1);
      total++; if (ls_done_out !== 1'b0) $display("[TB] FAIL st2_done_pulse got %b expected 0", ls_done_out); else passed++;
      total++; if (mem[16'h0200] !== 8'h34) $display("[TB] FAIL st2_mem200 got %h expected 34", mem[16'h0200]); else passed++;
      total++; if (mem[16'h0201] !== 8'h12) $display("[TB] FAIL st2_mem201 got %h expected 12", mem[16'h0201]); else passed++;
      total++; if (mem[16'h0202] !== 8'h77) $display("[TB] FAIL st2_mem202 got %h expected 77", mem[16'h0202]); else passed++;
   endtask

   task automatic test_io_stall;
      io_buffer_full_in = 1'b1;
      ls_addr_in = 32'h30000; ls_we_in = 1'b1; ls_size_in = 2'd0; ls_wdata_in = 32'h0000005A; ls_req_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1);
         total++; if (ram_wr_out !== 1'b0) $display("[TB] FAIL io_stall_wr[%0d] got %b expected 0", k, ram_wr_out); else passed++;
      end
      io_buffer_full_in = 1'b0;
      step(1);
      total++; if ({ram_wr_out, ram_a_out, ram_dout_out} !== {1'b1, 32'h30000, 8'h5A}) $display("[TB] FAIL io_write got wr=%b a=%h d=%h expected wr=1 a=00030000 d=5a", ram_wr_out, ram_a_out, ram_dout_out); else passed++;
      total++; if (ls_done_out !== 1'b0) $display("[TB] FAIL io_early_done got %b expected 0", ls_done_out); else passed++;
      step(1);
      total++; if (ls_done_out !== 1'b1) $display("[TB] FAIL io_done got %b expected 1", ls_done_out); else passed++;
      ls_req_in = 1'b0;
      step(1);
      total++; if (mem[16'h0000] !== 8'h5A) $display("[TB] FAIL io_mem got %h expected 5a", mem[16'h0000]); else passed++;
   endtask

   task automatic test_clear_fetch;
      if_addr_in = 32'h100; if_req_in = 1'b1;
      step(4);
      clear_in = 1'b1;
      step(1);
      total++; if (if_done_out !== 1'b0) $display("[TB] FAIL clr_fetch_no_done got %b expected 0", if_done_out); else passed++;
      total++; if (ram_a_out !== 32'h103) $display("[TB] FAIL clr_fetch_addr_hold got %h expected 00000103", ram_a_out); else passed++;
      clear_in = 1'b0; if_addr_in = 32'h300;
      step(1);
      total++; if (ram_a_out !== 32'h300) $display("[TB] FAIL clr_fetch_idle_regrant got %h expected 00000300", ram_a_out); else passed++;
      total++; if (if_done_out !== 1'b0) $display("[TB] FAIL clr_fetch_late_done got %b expected 0", if_done_out); else passed++;
      total++; if (if_data_out !== 32'h00000513) $display("[TB] FAIL clr_fetch_data_hold got %h expected 00000513", if_data_out); else passed++;
      step(5);
      total++; if (if_done_out !== 1'b1) $display("[TB] FAIL clr_refetch_done got %b expected 1", if_done_out); else passed++;
      total++; if (if_data_out !== 32'h44332211) $display("[TB] FAIL clr_refetch_data got %h expected 44332211", if_data_out); else passed++;
      if_req_in = 1'b0;
      step(1);
   endtask

   task automatic test_clear_store;
      logic [31:0] wexp;
      wexp = 32'hDEADBEEF;
      ls_addr_in = 32'h400; ls_we_in = 1'b1; ls_size_in = 2'd2; ls_wdata_in = wexp; ls_req_in = 1'b1;
      step(2);
      clear_in = 1'b1;
      step(1);
      clear_in = 1'b0;
      step(1);
      total++; if ({ram_wr_out, ram_a_out, ram_dout_out} !== {1'b1, 32'h403, 8'hDE}) $display("[TB] FAIL clr_st_byte3 got wr=%b a=%h d=%h expected wr=1 a=00000403 d=de", ram_wr_out, ram_a_out, ram_dout_out); else passed++;
      step(1);
      total++; if (ls_done_out !== 1'b1) $display("[TB] FAIL clr_st_done got %b expected 1", ls_done_out); else passed++;
      ls_req_in = 1'b0;
      step(1);
      for (int k = 0; k < 4; k++) begin
         total++; if (mem[16'h0400 + k] !== wexp[8*k +: 8]) $display("[TB] FAIL clr_st_mem[%0d] got %h expected %h", k, mem[16'h0400 + k], wexp[8*k +: 8]); else passed++;
      end
   endtask

   task automatic test_small_loads;
      ls_addr_in = 32'h300; ls_we_in = 1'b0; ls_size_in = 2'd0; ls_req_in = 1'b1;
      step(2);
      total++; if (ls_done_out !== 1'b0) $display("[TB] FAIL ld1_early_done got %b expected 0", ls_done_out); else passed++;
      step(1);
      total++; if (ls_done_out !== 1'b1) $display("[TB] FAIL ld1_done got %b expected 1", ls_done_out); else passed++;
      total++; if (ls_rdata_out !== 32'h00000011) $display("[TB] FAIL ld1_data got %h expected 00000011", ls_rdata_out); else passed++;
      ls_req_in = 1'b0;
      step(1);
      ls_addr_in = 32'h301; ls_size_in = 2'd1; ls_req_in = 1'b1;
      step(3);
      total++; if (ls_done_out !== 1'b0) $display("[TB] FAIL ld2_early_done got %b expected 0", ls_done_out); else passed++;
      step(1);
      total++; if (ls_done_out !== 1'b1) $display("[TB] FAIL ld2_done got %b expected 1", ls_done_out); else passed++;
      total++; if (ls_rdata_out !== 32'h00003322) $display("[TB] FAIL ld2_data got %h expected 00003322", ls_rdata_out); else passed++;
      ls_req_in = 1'b0;
      step(1);
   endtask

   task automatic test_rdy_load;
      ls_addr_in = 32'h300; ls_we_in = 1'b0; ls_size_in = 2'd2; ls_req_in = 1'b1;
      step(3);
      rdy = 1'b0;
      step(1);
      total++; if (ram_a_out !== 32'h302) $display("[TB] FAIL rdy_addr_hold got %h expected 00000302", ram_a_out); else passed++;
      step(1);
      rdy = 1'b1;
      step(1);
      total++; if (ls_done_out !== 1'b0) $display("[TB] FAIL rdy_nominal_done got %b expected 0", ls_done_out); else passed++;
      step(1);
      total++; if (ls_done_out !== 1'b0) $display("[TB] FAIL rdy_early_done got %b expected 0", ls_done_out); else passed++;
      step(1);
      total++; if (ls_done_out !== 1'b1) $display("[TB] FAIL rdy_done got %b expected 1", ls_done_out); else passed++;
      total++; if (ls_rdata_out !== 32'h44332211) $display("[TB] FAIL rdy_data got %h expected 44332211", ls_rdata_out); else passed++;
      ls_req_in = 1'b0;
      step(1);
   endtask

   task automatic test_rdy_store;
      ls_addr_in = 32'h500; ls_we_in = 1'b1; ls_size_in = 2'd0; ls_wdata_in = 32'h00000099; ls_req_in = 1'b1;
      step(1);
      total++; if (ram_wr_out !== 1'b1) $display("[TB] FAIL rdy_st_wr got %b expected 1", ram_wr_out); else passed++;
      rdy = 1'b0;
      #1;
      total++; if (ram_wr_out !== 1'b0) $display("[TB] FAIL rdy_st_wr_forced got %b expected 0", ram_wr_out); else passed++;
      step(1);
      rdy = 1'b1;
      #1;
      total++; if ({ram_wr_out, ram_a_out} !== {1'b1, 32'h500}) $display("[TB] FAIL rdy_st_resume got wr=%b a=%h expected wr=1 a=00000500", ram_wr_out, ram_a_out); else passed++;
      step(1);
      total++; if (ls_done_out !== 1'b1) $display("[TB] FAIL rdy_st_done got %b expected 1", ls_done_out); else passed++;
      total++; if (mem[16'h0500] !== 8'h99) $display("[TB] FAIL rdy_st_mem got %h expected 99", mem[16'h0500]); else passed++;
      ls_req_in = 1'b0;
      step(1);
   endtask

   task automatic test_reset_mid_load;
      ls_addr_in = 32'h100; ls_we_in = 1'b0; ls_size_in = 2'd2; ls_req_in = 1'b1;
      step(3);
      rst = 1'b1;
      step(1);
      total++; if (ram_a_out !== 32'd0) $display("[TB] FAIL rstmid_addr got %h expected 0", ram_a_out); else passed++;
      total++; if (ls_rdata_out !== 32'd0) $display("[TB] FAIL rstmid_ls_rdata got %h expected 0", ls_rdata_out); else passed++;
      total++; if (if_data_out !== 32'd0) $display("[TB] FAIL rstmid_if_data got %h expected 0", if_data_out); else passed++;
      total++; if (ram_dout_out !== 8'd0) $display("[TB] FAIL rstmid_dout got %h expected 0", ram_dout_out); else passed++;
      rst = 1'b0; ls_req_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(1);
         total++; if (ls_done_out !== 1'b0) $display("[TB] FAIL rstmid_no_done[%0d] got %b expected 0", k, ls_done_out); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_lone_fetch();
      test_round_robin();
      test_store_2b();
      test_io_stall();
      test_clear_fetch();
      test_clear_store();
      test_small_loads();
      test_rdy_load();
      test_rdy_store();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
